counter_load_scheduler: RTL and testbench
=========================================

COUNTER_LOAD_SCHEDULER -- requirements
Module: counter_load_scheduler

Interface
REQ-001 Parameters SHALL be: WDOG_MAX, default 255, RUN-state cycle limit before abort; DW, default 6, load data width.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a_valid  input  1  requester A has a load request.
REQ-005 a_data  input  DW  requester A load value.
REQ-006 a_target  input  8  requester A terminal count.
REQ-007 a_ready  output  1  scheduler accepts A this cycle.
REQ-008 b_valid / b_data / b_target / b_ready  same widths and meaning as REQ-004..007 for requester B.
REQ-009 count  input  8  current value of the managed programmable counter.
REQ-010 ctr_load  output  1  load strobe to the counter.
REQ-011 ctr_data  output  DW  load value to the counter.
REQ-012 ctr_oe_n  output  1  active-low counter output enable.
REQ-013 done  output  1  one-cycle pulse: terminal count reached.
REQ-014 err  output  1  one-cycle pulse: watchdog abort.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 owner  output  1  requester of the current job (0=A, 1=B), held from grant until return to IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, SETTLE, RUN.
REQ-018 Arbitration SHALL be round-robin on a last_grant bit: one valid -> that one; both valid -> the one not equal to last_grant.
REQ-019 a_ready/b_ready SHALL be combinational: high only in IDLE, only for the arbitration winner; never both high.
REQ-020 A transfer SHALL occur when valid and ready are both high in the same cycle; data and target SHALL be latched, last_grant and owner updated, and the FSM SHALL enter LOAD.
REQ-021 Deasserting valid before transfer SHALL be legal and SHALL leave state unchanged.
REQ-022 LOAD SHALL last exactly one cycle, driving ctr_load=1 and ctr_data=latched data; then SETTLE.
REQ-023 ctr_load SHALL be 0 in every state other than LOAD; ctr_data SHALL hold the last latched value otherwise.
REQ-024 SETTLE SHALL last exactly one cycle with ctr_load=0; then RUN.
REQ-025 ctr_oe_n SHALL be 0 in SETTLE and RUN, 1 in IDLE and LOAD.
REQ-026 In RUN, count SHALL be compared each cycle to the latched 8-bit target (unsigned equality).
REQ-027 On match, done SHALL pulse for that cycle and the FSM SHALL return to IDLE next cycle.
REQ-028 An 8-bit watchdog SHALL clear on RUN entry and increment each RUN cycle; on reaching WDOG_MAX without a match, err SHALL pulse and the FSM SHALL return to IDLE.
REQ-029 Match and watchdog expiry in the same cycle SHALL give done=1, err=0.
REQ-030 Earliest new grant after done/err SHALL be the cycle the FSM is back in IDLE (minimum accept-to-accept spacing: 4 cycles).
REQ-031 Requests arriving while busy SHALL wait; ready SHALL stay 0 until IDLE.

Reset
REQ-032 While reset is high, at the clock edge: state=IDLE, ctr_load=0, ctr_data=0, ctr_oe_n=1, done=0, err=0, busy=0, owner=0, watchdog=0, last_grant=1 (A wins first contest).
REQ-033 Reset asserted in any state SHALL abort the job without a done or err pulse; a_ready and b_ready SHALL be 0 during reset.

Verification
REQ-034 A only: a_valid=1, a_data=5, a_target=9, count driven 5,6,7,8,9 from SETTLE -> ctr_load pulse with ctr_data=5 one cycle after accept, done pulse when count=9, owner=0.
REQ-035 A and B valid together from reset -> A granted first, B granted at next IDLE, then A again if both still valid (alternation).
REQ-036 Target never matched, WDOG_MAX=255 -> err pulses after 255 RUN cycles, done stays 0, FSM returns to IDLE.
REQ-037 Reset asserted in RUN -> next cycle IDLE, ctr_oe_n=1, no done/err, first grant after reset goes to A.
REQ-038 b_valid toggles high for one cycle while busy -> no transfer, b_ready stays 0, running job unaffected.
REQ-039 Target equals count on the first RUN cycle while watchdog expires -> done=1, err=0.

Source files
------------

// File: rtl/counter_load_scheduler.sv
// Two-requester load scheduler for a programmable counter: round-robin grant,
// one-cycle load, one-cycle settle, then run until terminal count or watchdog abort.
module counter_load_scheduler #(
  parameter int WDOG_MAX = 255,
  parameter int DW       = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [DW-1:0] a_data,
  input  logic [7:0]    a_target,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [DW-1:0] b_data,
  input  logic [7:0]    b_target,
  output logic          b_ready,
  input  logic [7:0]    count,
  output logic          ctr_load,
  output logic [DW-1:0] ctr_data,
  output logic          ctr_oe_n,
  output logic          done,
  output logic          err,
  output logic          busy,
  output logic          owner,
  output logic [1:0]    dbg_state
);

  // Handshake: a request transfers on the rising edge where valid and ready
  // are both high. Ready is only offered in IDLE, only to the arbitration
  // winner, and never while reset is high; a requester may drop valid at any
  // time before the transfer without side effects.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [7:0]    target_q, target_d;
  logic [7:0]    wdog_q, wdog_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;

  logic pick_b;
  logic any_valid;
  logic match;
  logic expire;

  // B wins when it is alone, or when both ask and A was served last.
  assign any_valid = a_valid | b_valid;
  assign pick_b    = b_valid & (~a_valid | ~last_grant_q);
  assign match     = (count == target_q);
  assign expire    = (({1'b0, wdog_q} + 9'd1) == 9'(WDOG_MAX));

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    target_d     = target_q;
    wdog_d       = wdog_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    ctr_load     = 1'b0;
    ctr_oe_n     = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    busy         = 1'b1;

    case (state_q)
      S_IDLE: begin
        busy    = 1'b0;
        a_ready = a_valid & ~pick_b;
        b_ready = pick_b;
        if (any_valid) begin
          state_d      = S_LOAD;
          owner_d      = pick_b;
          last_grant_d = pick_b;
          data_d       = pick_b ? b_data : a_data;
          target_d     = pick_b ? b_target : a_target;
        end
      end
      S_LOAD: begin
        ctr_load = 1'b1;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        ctr_oe_n = 1'b0;
        wdog_d   = 8'd0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        ctr_oe_n = 1'b0;
        wdog_d   = wdog_q + 8'd1;
        // A match on the expiry cycle counts as a normal completion.
        if (match) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (expire) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (reset) begin
      a_ready  = 1'b0;
      b_ready  = 1'b0;
      ctr_load = 1'b0;
      ctr_oe_n = 1'b1;
      done     = 1'b0;
      err      = 1'b0;
      busy     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      data_q       <= '0;
      target_q     <= 8'd0;
      wdog_q       <= 8'd0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      target_q     <= target_d;
      wdog_q       <= wdog_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign ctr_data  = data_q;
  assign owner     = owner_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_counter_load_scheduler.sv
// Directed bench for counter_load_scheduler: a default instance plus a
// WDOG_MAX=1 instance for the match-versus-expiry corner.
module tb_counter_load_scheduler;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid, b_valid;
  logic [DW-1:0] a_data, b_data;
  logic [7:0]    a_target, b_target, count;

  logic          a_ready, b_ready, ctr_load, ctr_oe_n, done, err, busy, owner;
  logic [DW-1:0] ctr_data;
  logic [1:0]    dbg_state;

  logic          u1_a_ready, u1_b_ready, u1_ctr_load, u1_ctr_oe_n;
  logic          u1_done, u1_err, u1_busy, u1_owner;
  logic [DW-1:0] u1_ctr_data;
  logic [1:0]    u1_dbg_state;

  counter_load_scheduler #(.WDOG_MAX(255), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_target(a_target), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_target(b_target), .b_ready(b_ready),
    .count(count), .ctr_load(ctr_load), .ctr_data(ctr_data), .ctr_oe_n(ctr_oe_n),
    .done(done), .err(err), .busy(busy), .owner(owner), .dbg_state(dbg_state)
  );

  counter_load_scheduler #(.WDOG_MAX(1), .DW(DW)) dut1 (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_target(a_target), .a_ready(u1_a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_target(b_target), .b_ready(u1_b_ready),
    .count(count), .ctr_load(u1_ctr_load), .ctr_data(u1_ctr_data), .ctr_oe_n(u1_ctr_oe_n),
    .done(u1_done), .err(u1_err), .busy(u1_busy), .owner(u1_owner), .dbg_state(u1_dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: the LOAD cycle must present the oldest expected load value.
  task automatic expect_load(input string tag, input logic exp_owner);
    logic [DW-1:0] e;
    chk({tag, "_ld"}, 32'(ctr_load), 32'd1);
    chk({tag, "_oen"}, 32'(ctr_oe_n), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_own"}, 32'(owner), 32'(exp_owner));
    chk({tag, "_rdy"}, 32'({a_ready, b_ready}), 32'd0);
    chk({tag, "_sbq"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, 32'(ctr_data), 32'(e));
    end
  endtask

  // Job whose target already equals count: done on the first RUN cycle.
  task automatic run_match_job(input string tag, input logic exp_owner);
    settle();
    chk({tag, "_ardy"}, 32'(a_ready), 32'(!exp_owner));
    chk({tag, "_brdy"}, 32'(b_ready), 32'(exp_owner));
    tick();
    expect_load(tag, exp_owner);
    tick();
    chk({tag, "_set_ld"}, 32'(ctr_load), 32'd0);
    chk({tag, "_set_oen"}, 32'(ctr_oe_n), 32'd0);
    tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'd0);
    tick();
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_idle_oen"}, 32'(ctr_oe_n), 32'd1);
  endtask

  initial begin
    reset = 1'b1; a_valid = 1'b1; a_data = 6'd5; a_target = 8'd9;
    b_valid = 1'b0; b_data = '0; b_target = 8'd0; count = 8'd0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ld", 32'(ctr_load), 32'd0);
    chk("rst_data", 32'(ctr_data), 32'd0);
    chk("rst_oen", 32'(ctr_oe_n), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_own", 32'(owner), 32'd0);
    chk("rst_ardy", 32'(a_ready), 32'd0);
    chk("rst_brdy", 32'(b_ready), 32'd0);

    // A alone: load 5, count 5..9, done at 9
    reset = 1'b0;
    exp_q.push_back(6'd5);
    settle();
    chk("a_ardy", 32'(a_ready), 32'd1);
    chk("a_brdy", 32'(b_ready), 32'd0);
    tick();
    expect_load("a", 1'b0);
    a_valid = 1'b0;
    count = 8'd5;
    tick();
    chk("a_set_ld", 32'(ctr_load), 32'd0);
    chk("a_set_oen", 32'(ctr_oe_n), 32'd0);
    chk("a_set_hold", 32'(ctr_data), 32'd5);
    chk("a_set_done", 32'(done), 32'd0);
    tick();
    for (int v = 6; v <= 9; v++) begin
      count = 8'(v);
      settle();
      chk("a_run_done", 32'(done), 32'(v == 9));
      chk("a_run_err", 32'(err), 32'd0);
      if (v < 9) tick();
    end
    tick();
    chk("a_end_busy", 32'(busy), 32'd0);
    chk("a_end_oen", 32'(ctr_oe_n), 32'd1);

    // B pulses for one cycle while A's job is busy
    a_valid = 1'b1; a_data = 6'd7; a_target = 8'd3; count = 8'd0;
    exp_q.push_back(6'd7);
    settle();
    chk("bt_ardy", 32'(a_ready), 32'd1);
    tick();
    expect_load("bt", 1'b0);
    a_valid = 1'b0; b_valid = 1'b1; b_data = 6'd9; b_target = 8'd3;
    settle();
    chk("bt_brdy_busy", 32'(b_ready), 32'd0);
    tick();
    b_valid = 1'b0;
    tick();
    count = 8'd3;
    settle();
    chk("bt_done", 32'(done), 32'd1);
    chk("bt_own", 32'(owner), 32'd0);
    tick();
    chk("bt_idle_busy", 32'(busy), 32'd0);
    chk("bt_idle_brdy", 32'(b_ready), 32'd0);
    tick();
    chk("bt_no_xfer_busy", 32'(busy), 32'd0);
    chk("bt_no_xfer_ld", 32'(ctr_load), 32'd0);

    // Both valid from reset: A, B, A
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_valid = 1'b1; a_data = 6'd10; a_target = 8'd20;
    b_valid = 1'b1; b_data = 6'd20; b_target = 8'd20; count = 8'd20;
    exp_q.push_back(6'd10);
    exp_q.push_back(6'd20);
    exp_q.push_back(6'd10);
    run_match_job("alt_a1", 1'b0);
    run_match_job("alt_b", 1'b1);
    run_match_job("alt_a2", 1'b0);
    a_valid = 1'b0; b_valid = 1'b0;

    // Reset during RUN aborts silently; next contest goes to A
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_valid = 1'b1; a_data = 6'd3; a_target = 8'd50; count = 8'd0;
    exp_q.push_back(6'd3);
    tick();
    expect_load("rr", 1'b0);
    a_valid = 1'b0;
    tick();
    tick();
    chk("rr_run_done", 32'(done), 32'd0);
    chk("rr_run_oen", 32'(ctr_oe_n), 32'd0);
    tick();
    reset = 1'b1; count = 8'd50; a_valid = 1'b1; b_valid = 1'b1;
    settle();
    chk("rr_done", 32'(done), 32'd0);
    chk("rr_err", 32'(err), 32'd0);
    chk("rr_ardy", 32'(a_ready), 32'd0);
    chk("rr_brdy", 32'(b_ready), 32'd0);
    tick();
    chk("rr_idle_oen", 32'(ctr_oe_n), 32'd1);
    chk("rr_idle_busy", 32'(busy), 32'd0);
    chk("rr_idle_done", 32'(done), 32'd0);
    chk("rr_idle_data", 32'(ctr_data), 32'd0);
    reset = 1'b0;
    settle();
    chk("rr_first_ardy", 32'(a_ready), 32'd1);
    chk("rr_first_brdy", 32'(b_ready), 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();

    // Target never reached: err on the 255th RUN cycle
    a_valid = 1'b1; a_data = 6'd12; a_target = 8'd200; count = 8'd0;
    exp_q.push_back(6'd12);
    tick();
    expect_load("wd", 1'b0);
    a_valid = 1'b0;
    tick();
    tick();
    for (int k = 1; k <= 255; k++) begin
      chk("wd_err", 32'(err), 32'(k == 255));
      chk("wd_done", 32'(done), 32'd0);
      if (k < 255) tick();
    end
    tick();
    chk("wd_end_busy", 32'(busy), 32'd0);
    chk("wd_end_err", 32'(err), 32'd0);

    // WDOG_MAX=1: match on the expiry cycle wins, otherwise err
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_valid = 1'b1; a_data = 6'd33; a_target = 8'd33; count = 8'd33;
    exp_q.push_back(6'd33);
    tick();
    expect_load("w1", 1'b0);
    chk("w1_u1_ld", 32'(u1_ctr_load), 32'd1);
    a_valid = 1'b0;
    tick();
    tick();
    chk("w1_u1_done", 32'(u1_done), 32'd1);
    chk("w1_u1_err", 32'(u1_err), 32'd0);
    chk("w1_main_done", 32'(done), 32'd1);
    tick();
    chk("w1_u1_idle", 32'(u1_busy), 32'd0);
    a_valid = 1'b1; a_data = 6'd1; a_target = 8'd40; count = 8'd0;
    tick();
    a_valid = 1'b0;
    tick();
    tick();
    chk("w1x_u1_err", 32'(u1_err), 32'd1);
    chk("w1x_u1_done", 32'(u1_done), 32'd0);
    tick();
    chk("w1x_u1_idle", 32'(u1_busy), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
